// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one line-granular main_mem between two caches.
// Forwards the owner's handshake combinationally and latches each port's read line.
module mem_arbiter #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 p0_rd_req,
  input  logic                                 p0_wr_req,
  input  logic [ADDR_LEN-1:0]                  p0_addr,
  input  logic [32*(2**LINE_ADDR_LEN)-1:0]     p0_wr_line,
  output logic                                 p0_gnt,
  output logic [32*(2**LINE_ADDR_LEN)-1:0]     p0_rd_line,
  output logic [31:0]                          p0_cnt,
  input  logic                                 p1_rd_req,
  input  logic                                 p1_wr_req,
  input  logic [ADDR_LEN-1:0]                  p1_addr,
  input  logic [32*(2**LINE_ADDR_LEN)-1:0]     p1_wr_line,
  output logic                                 p1_gnt,
  output logic [32*(2**LINE_ADDR_LEN)-1:0]     p1_rd_line,
  output logic [31:0]                          p1_cnt,
  output logic                                 mem_rd_req,
  output logic                                 mem_wr_req,
  output logic [ADDR_LEN-1:0]                  mem_addr,
  output logic [32*(2**LINE_ADDR_LEN)-1:0]     mem_wr_line,
  input  logic                                 mem_gnt,
  input  logic [32*(2**LINE_ADDR_LEN)-1:0]     mem_rd_line
);

  localparam int LINE_SIZE = 2 ** LINE_ADDR_LEN;
  localparam int LINE_W    = 32 * LINE_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e              state_q;
  logic                rr_ptr_q;
  logic [31:0]         cnt0_q;
  logic [31:0]         cnt1_q;
  logic [31:0]         cnt0_d;
  logic [31:0]         cnt1_d;
  logic [LINE_W-1:0]   rd_line0_q;
  logic [LINE_W-1:0]   rd_line1_q;

  logic req0_s;
  logic req1_s;
  logic rd0_s;
  logic rd1_s;
  logic own0_s;
  logic own1_s;

  // A simultaneous rd+wr is treated as a write, so a read is only a pure read.
  assign req0_s = p0_rd_req | p0_wr_req;
  assign req1_s = p1_rd_req | p1_wr_req;
  assign rd0_s  = p0_rd_req & ~p0_wr_req;
  assign rd1_s  = p1_rd_req & ~p1_wr_req;
  assign own0_s = (state_q == OWN0);
  assign own1_s = (state_q == OWN1);
  assign cnt0_d = cnt0_q + 32'd1;
  assign cnt1_d = cnt1_q + 32'd1;

  assign p0_gnt     = own0_s & mem_gnt;
  assign p1_gnt     = own1_s & mem_gnt;
  assign p0_cnt     = cnt0_q;
  assign p1_cnt     = cnt1_q;
  assign p0_rd_line = rd_line0_q;
  assign p1_rd_line = rd_line1_q;

  // Owner's request is forwarded unregistered; IDLE keeps main_mem quiet.
  always_comb begin
    mem_rd_req  = 1'b0;
    mem_wr_req  = 1'b0;
    mem_addr    = {ADDR_LEN{1'b0}};
    mem_wr_line = {LINE_W{1'b0}};
    case (state_q)
      OWN0: begin
        mem_rd_req  = rd0_s;
        mem_wr_req  = p0_wr_req;
        mem_addr    = p0_addr;
        mem_wr_line = p0_wr_line;
      end
      OWN1: begin
        mem_rd_req  = rd1_s;
        mem_wr_req  = p1_wr_req;
        mem_addr    = p1_addr;
        mem_wr_line = p1_wr_line;
      end
      default: begin
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = {ADDR_LEN{1'b0}};
        mem_wr_line = {LINE_W{1'b0}};
      end
    endcase
  end

  // Arbitration FSM; every completion returns to IDLE so main_mem sees a request gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 1'b0;
      cnt0_q     <= 32'd0;
      cnt1_q     <= 32'd0;
      rd_line0_q <= {LINE_W{1'b0}};
      rd_line1_q <= {LINE_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_s && req1_s) begin
            state_q <= rr_ptr_q ? OWN1 : OWN0;
          end else if (req0_s) begin
            state_q <= OWN0;
          end else if (req1_s) begin
            state_q <= OWN1;
          end else begin
            state_q <= IDLE;
          end
        end
        OWN0: begin
          if (mem_gnt) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b1;
            cnt0_q   <= cnt0_d;
            if (rd0_s) begin
              rd_line0_q <= mem_rd_line;
            end
          end else if (!req0_s) begin
            state_q <= IDLE;
          end else begin
            state_q <= OWN0;
          end
        end
        OWN1: begin
          if (mem_gnt) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
            cnt1_q   <= cnt1_d;
            if (rd1_s) begin
              rd_line1_q <= mem_rd_line;
            end
          end else if (!req1_s) begin
            state_q <= IDLE;
          end else begin
            state_q <= OWN1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port round-robin arbiter that shares one line-granular main memory (main_mem) between two cache controllers, e.g. I-cache on port 0 and D-cache on port 1.
- Each port presents the same rd_req/wr_req/addr/wr_line/gnt/rd_line handshake that a cache presents to main_mem directly.
- It sits between the caches and a single main_mem instance.
- It latches each port's read line so the cache can capture it one cycle after gnt. It also counts completed transactions per port.

Parameters:
- LINE_ADDR_LEN, 3, line holds 2^LINE_ADDR_LEN 32-bit words (LINE_SIZE).
- ADDR_LEN, 9, line address width (tag+set bits).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, reset is asynchronous and active-high.
- p0_rd_req, p1_rd_req  in  1  line read request.
- p0_wr_req, p1_wr_req  in  1  line write request.
- p0_addr, p1_addr  in  ADDR_LEN  line address.
- p0_wr_line, p1_wr_line  in  32 x LINE_SIZE  write data.
- p0_gnt, p1_gnt  out  1  transaction done, 1-cycle pulse.
- p0_rd_line, p1_rd_line  out  32 x LINE_SIZE  latched read data.
- p0_cnt, p1_cnt  out  32  completed-transaction counters.
- mem_rd_req, mem_wr_req  out  1  to main_mem.
- mem_addr  out  ADDR_LEN  to main_mem.
- mem_wr_line  out  32 x LINE_SIZE  to main_mem.
- mem_gnt  in  1  main_mem handshake.
- mem_rd_line  in  32 x LINE_SIZE  main_mem read data.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0 (port 0 preferred).
  - p0/p1_rd_line all words 0; p0/p1_cnt=0.
  - All gnt, mem_rd_req and mem_wr_req are 0; mem_addr=0; mem_wr_line=0.
  - Reset mid-transaction abandons it; main_mem sees its request drop immediately.
- A port requests when pX_rd_req|pX_wr_req. If both rd and wr are high, the transaction is a write (the read is ignored).
- States: IDLE, OWN0, OWN1.
- IDLE:
  - All downstream requests and all gnt are 0.
  - Only port 0 requesting -> OWN0. Only port 1 -> OWN1.
  - Both requesting -> the port indicated by rr_ptr.
  - Arbitration latency is 1 cycle: the state is registered, and the downstream request appears in the first OWNx cycle.
- OWNx:
  - Combinational forwarding from owner x: mem_wr_req=pX_wr_req; mem_rd_req=pX_rd_req & ~pX_wr_req; mem_addr=pX_addr; mem_wr_line=pX_wr_line.
  - The non-owner sees gnt=0, its request is ignored and it stays pending.
  - pX_gnt = mem_gnt (same cycle, combinational) while in OWNx; the other gnt is forced 0.
  - On mem_gnt=1:
    - next state IDLE; rr_ptr <= other port; pX_cnt <= pX_cnt+1 (wraps 2^32-1 -> 0).
    - If the transaction was a read, pX_rd_line <= mem_rd_line at that edge.
  - Owner drops both requests without mem_gnt (abort): next state IDLE, no count, no latch, rr_ptr unchanged.
- After every completion, one IDLE cycle with downstream requests low is guaranteed. A new grant is not possible before gnt-edge+2, so main_mem always sees a request deassertion between transactions.
- pX_rd_line holds its value until that port's next completed read; a write or the other port's traffic never changes it.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1. A cache's SWAP_OUT then SWAP_IN may therefore be interleaved with the other port's transaction.
- The owner's address/data must stay stable until gnt. The arbiter does not register them.

Test Plan:
- Reset with all inputs 0 -> all outputs 0, state IDLE. Assert rst mid-OWN0 -> mem_rd_req falls in the same cycle, counts unchanged.
- Port 0 read addr=9'h012, main_mem returns words 0..7 = 0xA0..0xA7:
  - mem_rd_req rises 1 cycle after p0_rd_req; mem_addr=0x012.
  - p0_gnt pulses with mem_gnt.
  - Next cycle p0_rd_line=0xA0..0xA7; p0_cnt=1; p1_rd_line stays 0.
- Both ports request from IDLE after reset:
  - Port 0 completes first, then one IDLE cycle, then port 1 starts.
  - Two more simultaneous requests order 0,1 again; p0_cnt=2, p1_cnt=2.
- Port 1 write addr=0x1FF, line=0x11..0x18, while port 0 reads 0x003:
  - mem_wr_line/addr match port 1 only while OWN1.
  - p1_rd_line unchanged after the write.
  - Port 0 read returns its own data.
- Port 0 asserts rd_req and wr_req together -> mem_wr_req=1, mem_rd_req=0, p0_rd_line not updated.
- Port 0 drops its request in OWN0 before mem_gnt -> IDLE next cycle, p0_cnt unchanged. A pending port 1 request is granted next, since rr_ptr is unchanged but port 1 is the only requester.
